plot_buffer: RTL
================

PLOT_BUFFER -- requirements
Module: plot_buffer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and resetn.
REQ-002 Parameters SHALL be:
- N_COLS, default 20, number of plot columns and buffer depth.
- Y_ROWS, default 300, plot height in pixels.
- DATA_W, default 12, sample width in bits.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, pixel clock.
- resetn, in, 1, asynchronous active-low reset.
- sample_valid, in, 1, one-cycle strobe; sample_data is valid.
- sample_data, in, DATA_W, unsigned temperature code.
- clear, in, 1, one-cycle strobe that empties the buffer.
- matrix_x, in, 5, plot column index of the current pixel, from the grid template.
- matrix_y, in, 9, plot row index, 0 at the top.
- in_plot, in, 1, current pixel lies inside the plot area.
- plot_pixel, out, 1, draw a trace pixel here.
- count, out, 5, number of stored samples.
- full, out, 1, count equals N_COLS.
- latest, out, DATA_W, most recent raw sample.

Function
REQ-004 The write side SHALL be a state machine with states EMPTY, FILL and WRAP.
REQ-005 Transitions SHALL be:
- EMPTY to FILL on sample_valid.
- FILL to WRAP on the write that makes count equal N_COLS.
- Any state to EMPTY on clear.
REQ-006 Each stored value SHALL be scaled as: v = min(sample_data, Y_ROWS-1), then written as 9 bits.
REQ-007 Writes SHALL go to wr_ptr, and wr_ptr SHALL increment modulo N_COLS: after N_COLS-1 it returns to 0.
REQ-008 In EMPTY and FILL, count SHALL increment by 1 on each write.
REQ-009 In WRAP, count SHALL stay at N_COLS and each write SHALL overwrite the oldest entry.
REQ-010 latest SHALL take the raw sample_data value one cycle after an accepted write.
REQ-011 If clear and sample_valid are asserted in the same cycle, clear SHALL win and the sample SHALL be dropped.
REQ-012 On clear, the next cycle SHALL show count=0, full=0, wr_ptr=0 and latest unchanged.
REQ-013 Display order SHALL place the oldest sample in column 0: column c reads entry (base + c) mod N_COLS.
REQ-014 base SHALL be wr_ptr in WRAP and 0 otherwise.
REQ-015 A pixel SHALL be lit when all of the following hold, where v is the stored value of column c:
- in_plot=1;
- matrix_x < count;
- |matrix_y - (Y_ROWS-1-v)| <= 1 (a 3-pixel marker), with the 3-pixel window clipped at rows 0 and Y_ROWS-1.
REQ-016 matrix_x >= N_COLS SHALL never light a pixel.
REQ-017 The read side SHALL be a two-stage pipeline:
- stage 1 registers matrix_x, matrix_y and in_plot, and forms the read address;
- stage 2 registers the compare result onto plot_pixel.
REQ-018 plot_pixel SHALL therefore have a fixed latency of 2 clk cycles from the inputs.
REQ-019 A write during a read of the same entry SHALL return the old value in that read (read-before-write).
REQ-020 The read pipeline SHALL keep running during clear; the display SHALL be blank from 2 cycles after clear.

Reset
REQ-021 While resetn=0, the block SHALL hold state=EMPTY, wr_ptr=0, count=0, full=0, latest=0, plot_pixel=0 and all pipeline registers at 0.
REQ-022 Buffer contents SHALL not be reset; they are invisible while count=0.
REQ-023 When resetn is asserted mid-operation, the block SHALL discard any pending write and return to EMPTY asynchronously.

Structure
REQ-024 A shared package SHALL hold N_COLS, Y_ROWS, DATA_W, the state encoding (EMPTY=0, FILL=1, WRAP=2) and the 3-pixel marker half-width constant (1).
REQ-025 Storage SHALL be a single sub-module, sample_ram: N_COLS x 9 bits, one synchronous write port and one synchronous read port, inferable as distributed RAM.
REQ-026 Scaling, pointer logic, the FSM and the pixel compare SHALL remain in plot_buffer.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then sample_valid with data=100 -> count=1, latest=100, and pixel (x=0, y=199) lit 2 cycles after it is presented; y=198 and y=200 lit; y=197 not lit.
- Write 20 samples with data=0..19 -> full=1, state WRAP; a 21st write of 250 -> count=20, column 0 shows value 1, column 19 shows 250 (row 49 lit).
- Write data=4095 -> stored as 299; row 0 lit and row 1 lit at that column; no lit pixel outside rows 0-1.
- clear and sample_valid in the same cycle -> count=0 next cycle, the sample is not stored, and all plot_pixel are 0 from 2 cycles later.
- matrix_x=25, or in_plot=0, over a stored column -> plot_pixel=0.
- resetn pulled low mid-write in WRAP -> outputs go to reset values immediately; after release, the first write lands at column 0.

Source files
------------

// File: rtl/plot_buffer_pkg.sv
// Shared constants and types for the plot trace buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package plot_buffer_pkg;

  localparam int N_COLS  = 20;   // plot columns == buffer depth
  localparam int Y_ROWS  = 300;  // plot height in pixels
  localparam int DATA_W  = 12;   // raw sample width
  localparam int X_W     = 5;    // column index / count width
  localparam int ROW_W   = 9;    // stored value / row index width
  localparam int MARK_HW = 1;    // marker half-width: 2*MARK_HW+1 rows lit

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    WRAP  = 2'd2
  } state_t;

endpackage

// File: rtl/plot_buffer_sample_ram.sv
// sample_ram: DEPTH x W storage, one synchronous write port, one registered read port.
// Latency: rdata 1 clk after raddr; a same-cycle write to that entry returns the old value.
// Backpressure: none; write and read are accepted every cycle.
module sample_ram #(
  parameter int DEPTH = 20,
  parameter int W     = 9,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Storage array has no reset; stale entries are masked by count upstream.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register samples the pre-write contents, giving read-before-write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/plot_buffer.sv
// plot_buffer: ring buffer of scaled samples rendered as a 3-pixel trace, oldest sample in column 0.
// Latency: plot_pixel 2 clk after matrix_x/matrix_y/in_plot; count/full/latest 1 clk after a write.
// Backpressure: none; every sample_valid is taken unless clear is high in the same cycle.
module plot_buffer #(
  parameter int N_COLS = plot_buffer_pkg::N_COLS,
  parameter int Y_ROWS = plot_buffer_pkg::Y_ROWS,
  parameter int DATA_W = plot_buffer_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              clear,
  input  logic [4:0]        matrix_x,
  input  logic [8:0]        matrix_y,
  input  logic              in_plot,
  output logic              plot_pixel,
  output logic [4:0]        count,
  output logic              full,
  output logic [DATA_W-1:0] latest
);
  import plot_buffer_pkg::*;

  localparam logic [ROW_W-1:0] V_MAX = ROW_W'(Y_ROWS - 1);

  state_t            state_q, state_d;
  logic [X_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [X_W-1:0]    count_q, count_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] latest_q, latest_d;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_val;

  // Clamp the raw code to the plot height before storing.
  always_comb begin
    wr_val = V_MAX;
    if (sample_data < DATA_W'(Y_ROWS - 1)) wr_val = sample_data[ROW_W-1:0];
  end

  // Write-side next state: clear beats a coincident sample, WRAP overwrites the oldest entry.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    latest_d = latest_q;
    wr_en    = 1'b0;
    if (clear) begin
      state_d  = EMPTY;
      wr_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
    end else if (sample_valid) begin
      wr_en    = 1'b1;
      latest_d = sample_data;
      wr_ptr_d = (wr_ptr_q == X_W'(N_COLS - 1)) ? '0 : wr_ptr_q + X_W'(1);
      if (state_q != WRAP) begin
        count_d = count_q + X_W'(1);
        if (count_d == X_W'(N_COLS)) begin
          state_d = WRAP;
          full_d  = 1'b1;
        end else begin
          state_d = FILL;
        end
      end
    end
  end

  // Write-side FSM and its registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      latest_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      latest_q <= latest_d;
    end
  end

  logic [X_W-1:0]   base, rd_addr;
  logic [X_W:0]     addr_sum;
  logic [ROW_W-1:0] rd_val;

  // Rotate the column index so the oldest sample lands in column 0.
  always_comb begin
    base     = (state_q == WRAP) ? wr_ptr_q : '0;
    addr_sum = {1'b0, base} + {1'b0, matrix_x};
    rd_addr  = '0;
    if (matrix_x < X_W'(N_COLS)) begin
      rd_addr = (addr_sum >= (X_W+1)'(N_COLS)) ? X_W'(addr_sum - (X_W+1)'(N_COLS))
                                                : addr_sum[X_W-1:0];
    end
  end

  sample_ram #(
    .DEPTH (N_COLS),
    .W     (ROW_W),
    .AW    (X_W)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (wr_en),
    .waddr  (wr_ptr_q),
    .wdata  (wr_val),
    .raddr  (rd_addr),
    .rdata  (rd_val)
  );

  logic [X_W-1:0]   x_s1_q;
  logic [ROW_W-1:0] y_s1_q;
  logic             in_plot_s1_q;
  logic             plot_pixel_q, plot_pixel_d;
  logic [ROW_W:0]   row, y_ext;
  logic             near;

  // Marker test: pixel within MARK_HW rows of the trace row, never below the bottom row.
  always_comb begin
    row          = (ROW_W+1)'(Y_ROWS - 1) - {1'b0, rd_val};
    y_ext        = {1'b0, y_s1_q};
    near         = (y_ext + (ROW_W+1)'(MARK_HW) >= row) &&
                   (y_ext <= row + (ROW_W+1)'(MARK_HW)) &&
                   (y_ext <= (ROW_W+1)'(Y_ROWS - 1));
    plot_pixel_d = in_plot_s1_q && (x_s1_q < count_q) && (x_s1_q < X_W'(N_COLS)) && near;
  end

  // Two-stage read pipeline: stage 1 holds pixel coordinates, stage 2 the lit decision.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_s1_q       <= '0;
      y_s1_q       <= '0;
      in_plot_s1_q <= 1'b0;
      plot_pixel_q <= 1'b0;
    end else begin
      x_s1_q       <= matrix_x;
      y_s1_q       <= matrix_y;
      in_plot_s1_q <= in_plot;
      plot_pixel_q <= plot_pixel_d;
    end
  end

  assign plot_pixel = plot_pixel_q;
  assign count      = count_q;
  assign full       = full_q;
  assign latest     = latest_q;

endmodule
